sdram_arbit: RTL and testbench
==============================

# sdram_arbit

SDRAM command arbiter between the power-up init sequencer, the auto-refresh generator and the write/read burst engines of the UART-to-SDRAM path. Grants the single SDRAM command/address/data bus to one requester at a time: refresh first, then write, then read. Muxes the granted requester's command, bank, address and write data onto the SDRAM pins.

## Interface
- DATA_W, 16: SDRAM data width.
- ADDR_W, 13: SDRAM row/column address width.
- sys_clk  in  1  100 MHz system clock.
- sys_rst  in  1  reset, synchronous to sys_clk, active-high.
- init_end  in  1  init sequencer done (level, stays high).
- init_cmd / init_ba / init_addr  in  4 / 2 / ADDR_W  init sequencer bus.
- aref_req  in  1  refresh request (level, cleared by the refresh block).
- aref_end  in  1  one-cycle refresh-complete pulse.
- aref_cmd / aref_ba / aref_addr  in  4 / 2 / ADDR_W  refresh bus.
- wr_req, wr_end  in  1 each  write request (level) / one-cycle burst done.
- wr_cmd / wr_ba / wr_addr  in  4 / 2 / ADDR_W  write engine bus.
- wr_sdram_en  in  1  write engine drives data this cycle.
- wr_sdram_data  in  DATA_W  write data.
- rd_req, rd_end  in  1 each  read request (level) / one-cycle burst done.
- rd_cmd / rd_ba / rd_addr  in  4 / 2 / ADDR_W  read engine bus.
- aref_en, wr_en, rd_en  out  1 each  grant to refresh / write / read engine.
- sdram_cke  out  1  clock enable, constant 1.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins = cmd[3:0].
- sdram_ba  out  2  bank.
- sdram_addr  out  ADDR_W  address.
- sdram_dq_out  out  DATA_W  write data to pad.
- sdram_dq_oe  out  1  pad output enable.

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ; registered, reset to INIT.
- INIT -> ARBIT when init_end=1.
- ARBIT: aref_req -> AREF; else wr_req -> WRITE; else rd_req -> READ; else stay. Simultaneous requests resolve by this order.
- AREF -> ARBIT on aref_end; WRITE -> ARBIT on wr_end; READ -> ARBIT on rd_end. Requests arriving mid-burst are held off; engines must end their own bursts when they see aref_req.
- Grants: aref_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ); combinational state decode, one-hot or zero.
- Bus mux (combinational on state): INIT -> init bus; AREF -> aref bus; WRITE -> wr bus; READ -> rd bus; ARBIT -> NOP 4'b0111, ba 2'b11, addr all-ones.
- sdram_dq_oe = (state==WRITE) & wr_sdram_en; sdram_dq_out = wr_sdram_data when oe, else 0.
- An *_end pulse in a state other than its own is ignored.

## Timing
- Reset (sys_rst=1 at a sys_clk edge): state=INIT next cycle; all grants 0; pins follow init bus; dq_oe=0, dq_out=0; cke=1.
- Reset mid-burst: same as above, no completion required.
- Grant latency: request seen in ARBIT at edge N -> grant high in cycle N+1.
- Release: *_end high at edge N -> state ARBIT, grant low in cycle N+1; earliest new grant N+2. Minimum one ARBIT (NOP) cycle between bursts.
- Pin outputs are combinational from state and requester buses; no added latency.

## Configuration
- SDRAM_ARBIT_RR_EN defined: write/read tie broken round-robin; a 1-bit last-grant register (reset to read) gives priority to the engine not served last. Refresh still highest.
- Undefined: fixed write-over-read priority; no last-grant register.

## Structure
- Shared package sdram_pkg: command encodings (NOP 4'b0111, P_CHARGE 4'b0010, AUTO_REF 4'b0001, ACTIVE, WRITE, READ, BURST_STOP, MODE_REG), arbiter state encodings, DATA_W/ADDR_W defaults, idle ba/addr constants.
- One sub-module sdram_arbit_sel: combinational next-grant select from aref_req/wr_req/rd_req and last-grant (RR variant); top holds state register and muxes.

## Test plan
- Reset then init_end=1 at cycle 10 -> state ARBIT at 11, pins NOP, ba=2'b11, addr=13'h1fff, all grants 0.
- aref_req, wr_req, rd_req all high in ARBIT -> aref_en=1 next cycle; aref_end pulse -> one NOP cycle, then wr_en=1.
- Write grant, wr_sdram_en=1 with data 16'hA55A -> dq_oe=1, dq_out=16'hA55A, pins = wr_cmd; rd_req held -> rd_en only after wr_end plus one cycle.
- aref_req rises during READ -> rd_en stays 1 until rd_end, then aref_en=1 (before pending wr_req).
- sys_rst=1 mid-WRITE -> next cycle wr_en=0, dq_oe=0, state INIT, pins = init bus.
- With SDRAM_ARBIT_RR_EN: wr_req and rd_req held high continuously -> grants alternate WRITE, READ, WRITE; without it -> WRITE every time.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions for the UART-to-SDRAM path.
// Contents:
//   - SDRAM command encodings, as {cs_n, ras_n, cas_n, we_n}.
//   - Arbiter state encoding.
//   - Default data and address widths.
//   - The bank value the arbiter drives while it is idle.
package sdram_pkg;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 13;

  localparam logic [3:0] CmdNop       = 4'b0111;
  localparam logic [3:0] CmdPCharge   = 4'b0010;
  localparam logic [3:0] CmdAutoRef   = 4'b0001;
  localparam logic [3:0] CmdActive    = 4'b0011;
  localparam logic [3:0] CmdWrite     = 4'b0100;
  localparam logic [3:0] CmdRead      = 4'b0101;
  localparam logic [3:0] CmdBurstStop = 4'b0110;
  localparam logic [3:0] CmdModeReg   = 4'b0000;

  localparam logic [1:0] IdleBa = 2'b11;

  typedef enum logic [2:0] {
    StInit,
    StArbit,
    StAref,
    StWrite,
    StRead
  } arbit_state_e;

endpackage

// File: rtl/sdram_arbit_sel.sv
// Next-grant select for the SDRAM arbiter (purely combinational).
// Priority order: refresh first, then write, then read.
// Optional macro SDRAM_ARBIT_RR_EN: a write/read tie goes to the engine that was not served last.
// Ports:
//   aref_req, wr_req, rd_req : request levels.
//   last_wr                  : 1 when write was the last engine granted (RR build only).
//   next_grant               : state to enter from ARBIT; StArbit when no request is pending.
module sdram_arbit_sel
  import sdram_pkg::*;
(
  input  logic         aref_req,
  input  logic         wr_req,
  input  logic         rd_req,
`ifdef SDRAM_ARBIT_RR_EN
  input  logic         last_wr,
`endif
  output arbit_state_e next_grant
);

  always_comb begin
    next_grant = StArbit;
    if (aref_req) begin
      next_grant = StAref;
    end else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
      next_grant = last_wr ? StRead : StWrite;
`else
      next_grant = StWrite;
`endif
    end else if (wr_req) begin
      next_grant = StWrite;
    end else if (rd_req) begin
      next_grant = StRead;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter between the four bus owners:
//   - init sequencer
//   - auto-refresh
//   - write burst engine
//   - read burst engine
// It holds the ownership state and muxes the owner's command, bank, address and write data onto
// the SDRAM pins. Pin outputs are combinational from the state and the requester buses.
// Optional macro SDRAM_ARBIT_RR_EN: round-robin between write and read, using a 1-bit last-grant
// register.
// Ports:
//   sys_clk, sys_rst                  : clock; synchronous active-high reset.
//   init_*, aref_*, wr_*, rd_*        : requester handshakes and command buses.
//   wr_sdram_en, wr_sdram_data        : write data and its valid strobe.
//   aref_en, wr_en, rd_en             : grants.
//   sdram_cke                         : clock enable.
//   sdram_cs_n/ras_n/cas_n/we_n       : command pins.
//   sdram_ba, sdram_addr              : bank and address pins.
//   sdram_dq_out, sdram_dq_oe         : data pad drive and its output enable.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe
);

  arbit_state_e state_q;
  arbit_state_e next_grant;
  logic [3:0]   cmd;

`ifdef SDRAM_ARBIT_RR_EN
  logic last_wr_q;  // 0 = read served last, which is also the reset value
`endif

  sdram_arbit_sel u_sel (
    .aref_req   (aref_req),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
`ifdef SDRAM_ARBIT_RR_EN
    .last_wr    (last_wr_q),
`endif
    .next_grant (next_grant)
  );

  // Each *_end pulse is honoured only in its own state, so a stray pulse cannot end another burst.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StInit;
`ifdef SDRAM_ARBIT_RR_EN
      last_wr_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StInit:  if (init_end) state_q <= StArbit;
        StArbit: begin
          state_q <= next_grant;
`ifdef SDRAM_ARBIT_RR_EN
          if (next_grant == StWrite) last_wr_q <= 1'b1;
          else if (next_grant == StRead) last_wr_q <= 1'b0;
`endif
        end
        StAref:  if (aref_end) state_q <= StArbit;
        StWrite: if (wr_end) state_q <= StArbit;
        StRead:  if (rd_end) state_q <= StArbit;
        default: state_q <= StInit;
      endcase
    end
  end

  assign aref_en   = (state_q == StAref);
  assign wr_en     = (state_q == StWrite);
  assign rd_en     = (state_q == StRead);
  assign sdram_cke = 1'b1;

  always_comb begin
    cmd        = CmdNop;
    sdram_ba   = IdleBa;
    sdram_addr = '1;
    unique case (state_q)
      StInit: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      StAref: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      StWrite: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      StRead: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  assign sdram_dq_oe  = (state_q == StWrite) && wr_sdram_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

  localparam int DW = 16;
  localparam int AW = 13;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          init_end;
  logic [3:0]    init_cmd;
  logic [1:0]    init_ba;
  logic [AW-1:0] init_addr;
  logic          aref_req;
  logic          aref_end;
  logic [3:0]    aref_cmd;
  logic [1:0]    aref_ba;
  logic [AW-1:0] aref_addr;
  logic          wr_req;
  logic          wr_end;
  logic [3:0]    wr_cmd;
  logic [1:0]    wr_ba;
  logic [AW-1:0] wr_addr;
  logic          wr_sdram_en;
  logic [DW-1:0] wr_sdram_data;
  logic          rd_req;
  logic          rd_end;
  logic [3:0]    rd_cmd;
  logic [1:0]    rd_ba;
  logic [AW-1:0] rd_addr;
  logic          aref_en;
  logic          wr_en;
  logic          rd_en;
  logic          sdram_cke;
  logic          sdram_cs_n;
  logic          sdram_ras_n;
  logic          sdram_cas_n;
  logic          sdram_we_n;
  logic [1:0]    sdram_ba;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_dq_out;
  logic          sdram_dq_oe;

  sdram_arbit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .init_end      (init_end),
    .init_cmd      (init_cmd),
    .init_ba       (init_ba),
    .init_addr     (init_addr),
    .aref_req      (aref_req),
    .aref_end      (aref_end),
    .aref_cmd      (aref_cmd),
    .aref_ba       (aref_ba),
    .aref_addr     (aref_addr),
    .wr_req        (wr_req),
    .wr_end        (wr_end),
    .wr_cmd        (wr_cmd),
    .wr_ba         (wr_ba),
    .wr_addr       (wr_addr),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data),
    .rd_req        (rd_req),
    .rd_end        (rd_end),
    .rd_cmd        (rd_cmd),
    .rd_ba         (rd_ba),
    .rd_addr       (rd_addr),
    .aref_en       (aref_en),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .sdram_cke     (sdram_cke),
    .sdram_cs_n    (sdram_cs_n),
    .sdram_ras_n   (sdram_ras_n),
    .sdram_cas_n   (sdram_cas_n),
    .sdram_we_n    (sdram_we_n),
    .sdram_ba      (sdram_ba),
    .sdram_addr    (sdram_addr),
    .sdram_dq_out  (sdram_dq_out),
    .sdram_dq_oe   (sdram_dq_oe)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Bus owner in the model: 0 init, 1 idle (NOP), 2 refresh, 3 write, 4 read.
  int   m_owner   = 0;
  logic m_last_wr = 1'b0;

  typedef struct {
    logic [8:0] stim;  // rst, init_end, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end, wr_en
    int         owner;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [39:0] expect_out(int owner);
    logic [3:0]    c;
    logic [1:0]    b;
    logic [AW-1:0] a;
    logic          oe;
    case (owner)
      0:       begin c = init_cmd; b = init_ba; a = init_addr; end
      2:       begin c = aref_cmd; b = aref_ba; a = aref_addr; end
      3:       begin c = wr_cmd;   b = wr_ba;   a = wr_addr;   end
      4:       begin c = rd_cmd;   b = rd_ba;   a = rd_addr;   end
      default: begin c = 4'b0111;  b = 2'b11;   a = '1;        end
    endcase
    oe = (owner == 3) && wr_sdram_en;
    return {owner == 2, owner == 3, owner == 4, 1'b1, c, b, a, oe, oe ? wr_sdram_data : 16'h0000};
  endfunction

  function automatic logic [39:0] observed();
    return {aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
            sdram_ba, sdram_addr, sdram_dq_oe, sdram_dq_out};
  endfunction

  task automatic check(input string name, input int owner);
    logic [39:0] got;
    logic [39:0] want;
    got  = observed();
    want = expect_out(owner);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (owner %0d)", name, got, want, owner);
    end
  endtask

  // Ownership rules applied at a clock edge, using the inputs present at that edge.
  task automatic model_step();
    if (sys_rst) begin
      m_owner   = 0;
      m_last_wr = 1'b0;
    end else begin
      case (m_owner)
        0: if (init_end) m_owner = 1;
        1: begin
          if (aref_req) m_owner = 2;
          else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
            m_owner = m_last_wr ? 4 : 3;
`else
            m_owner = 3;
`endif
          end else if (wr_req) m_owner = 3;
          else if (rd_req) m_owner = 4;
          if (m_owner == 3) m_last_wr = 1'b1;
          if (m_owner == 4) m_last_wr = 1'b0;
        end
        2: if (aref_end) m_owner = 1;
        3: if (wr_end) m_owner = 1;
        4: if (rd_end) m_owner = 1;
        default: m_owner = 0;
      endcase
    end
  endtask

  task automatic apply_stim(input logic [8:0] s);
    {sys_rst, init_end, aref_req, wr_req, rd_req, aref_end, wr_end, rd_end, wr_sdram_en} = s;
  endtask

  initial begin
    int          grants[$];
    int          exp_g[3];
    int          cyc;
    logic [39:0] nop_vec;

    init_cmd = 4'b0010; init_ba = 2'd0; init_addr = 13'h0111;
    aref_cmd = 4'b0001; aref_ba = 2'd1; aref_addr = 13'h0222;
    wr_cmd   = 4'b0100; wr_ba   = 2'd2; wr_addr   = 13'h0333;
    rd_cmd   = 4'b0101; rd_ba   = 2'd3; rd_addr   = 13'h0444;
    wr_sdram_data = 16'hA55A;
    apply_stim(9'b1_0_000_000_0);

    tbl[0]  = '{9'b1_0_000_000_0, 0};  // reset
    tbl[1]  = '{9'b0_0_000_000_0, 0};  // waiting for init
    tbl[2]  = '{9'b0_1_000_000_0, 1};  // init done -> NOP
    tbl[3]  = '{9'b0_1_111_000_0, 2};  // all requests -> refresh wins
    tbl[4]  = '{9'b0_1_111_000_0, 2};
    tbl[5]  = '{9'b0_1_011_100_0, 1};  // refresh end -> one NOP cycle
    tbl[6]  = '{9'b0_1_011_000_0, 3};  // write before read
    tbl[7]  = '{9'b0_1_011_000_1, 3};  // write data on pad
    tbl[8]  = '{9'b0_1_001_010_1, 1};  // wr_end -> NOP, oe drops
    tbl[9]  = '{9'b0_1_001_000_0, 4};  // read granted
    tbl[10] = '{9'b0_1_111_000_0, 4};  // refresh held off mid-read
    tbl[11] = '{9'b0_1_110_001_0, 1};  // rd_end -> NOP
    tbl[12] = '{9'b0_1_110_000_0, 2};  // refresh ahead of pending write
    tbl[13] = '{9'b0_1_110_011_0, 2};  // stray ends ignored
    tbl[14] = '{9'b0_1_010_100_0, 1};
    tbl[15] = '{9'b0_1_010_000_1, 3};
    tbl[16] = '{9'b1_1_010_000_1, 0};  // reset mid-write
    tbl[17] = '{9'b0_1_000_000_0, 1};

    @(negedge sys_clk);
    for (int i = 0; i < 18; i++) begin
      apply_stim(tbl[i].stim);
      @(posedge sys_clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].owner);
    end

    // Write/read contention held high: sequence of three grants.
    apply_stim(9'b1_0_000_000_0);
    @(posedge sys_clk); #1;
    apply_stim(9'b0_1_000_000_0);
    @(posedge sys_clk); #1;
    wr_req = 1'b1;
    rd_req = 1'b1;
`ifdef SDRAM_ARBIT_RR_EN
    exp_g = '{3, 4, 3};
`else
    exp_g = '{3, 3, 3};
`endif
    for (int g = 0; g < 3; g++) begin
      cyc = 0;
      @(posedge sys_clk); #1;
      while (!(wr_en || rd_en) && cyc < 10) begin
        @(posedge sys_clk); #1;
        cyc++;
      end
      total++;
      if (wr_en === 1'b1 && exp_g[g] == 3) grants.push_back(3);
      else if (rd_en === 1'b1 && exp_g[g] == 4) grants.push_back(4);
      else begin
        bad++;
        $display("FAIL contend%0d: wr_en=%b rd_en=%b want owner %0d", g, wr_en, rd_en, exp_g[g]);
      end
      if (wr_en) wr_end = 1'b1;
      if (rd_en) rd_end = 1'b1;
      @(posedge sys_clk); #1;
      wr_end = 1'b0;
      rd_end = 1'b0;
      nop_vec = observed();
      total++;
      if (nop_vec[39:37] !== 3'b000 || nop_vec[35:32] !== 4'b0111) begin
        bad++;
        $display("FAIL contend_nop%0d: got %h want grants 000 cmd 0111", g, nop_vec);
      end
    end

    // Randomized traffic against the model.
    apply_stim(9'b1_0_000_000_0);
    for (int n = 0; n < 3000; n++) begin
      if (n == 0) sys_rst = 1'b1;
      else sys_rst = ($urandom_range(0, 99) == 0);
      init_end      = ($urandom_range(0, 3) != 0);
      aref_req      = ($urandom_range(0, 4) == 0);
      wr_req        = 1'($urandom_range(0, 1));
      rd_req        = 1'($urandom_range(0, 1));
      aref_end      = ($urandom_range(0, 3) == 0);
      wr_end        = ($urandom_range(0, 3) == 0);
      rd_end        = ($urandom_range(0, 3) == 0);
      wr_sdram_en   = 1'($urandom_range(0, 1));
      wr_sdram_data = 16'($urandom);
      init_cmd      = 4'($urandom);
      init_ba       = 2'($urandom);
      init_addr     = 13'($urandom);
      aref_cmd      = 4'($urandom);
      aref_ba       = 2'($urandom);
      aref_addr     = 13'($urandom);
      wr_cmd        = 4'($urandom);
      wr_ba         = 2'($urandom);
      wr_addr       = 13'($urandom);
      rd_cmd        = 4'($urandom);
      rd_ba         = 2'($urandom);
      rd_addr       = 13'($urandom);
      #1;
      if (n > 0) check($sformatf("rand%0d", n), m_owner);
      @(posedge sys_clk);
      model_step();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
